regfile_mp: RTL and testbench

Parametrised multi-port register file, the next-generation register file of the ARM-like CPU core: three combinational read ports, two write ports and a top-index register aliased to the externally supplied PC. It adds three things to the CPU's register file:
- a post-reset clear sequencer that zeroes every general register;
- deterministic dual-write priority;
- a registered PC-write notification for the fetch stage.

It sits between decode (read addresses) and writeback (ALU result on port 3, load/base-writeback data on port 4).

---
 rtl/regfile_mp_if.sv | 33 +++
 rtl/regfile_mp.sv | 119 +++++++++++
 tb/tb_regfile_mp.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// ============================================================================
// Module      : regfile_mp_if
// Description : Read/write port bundle for the multi-port register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] ra1, ra2, ra3;
    logic [DATA_W-1:0] rd1, rd2, rd3;
    logic [DATA_W-1:0] R15;
    logic              we3, we4;
    logic [ADDR_W-1:0] wa3, wa4;
    logic [DATA_W-1:0] wd3, wd4;
    logic              busy;
    logic              pc_wr;
    logic [DATA_W-1:0] pc_wd;

    modport slave (
        input  ra1, ra2, ra3, R15, we3, wa3, wd3, we4, wa4, wd4,
        output rd1, rd2, rd3, busy, pc_wr, pc_wd
    );

    modport master (
        output ra1, ra2, ra3, R15, we3, wa3, wd3, we4, wa4, wd4,
        input  rd1, rd2, rd3, busy, pc_wr, pc_wd
    );
endinterface

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module      : regfile_mp
// Description : 3-read / 2-write register file with post-reset clear
//               sequencer, PC alias at the top index and PC-write pulse.
//               Define REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  wire logic   clk,
    input  wire logic   reset,
    regfile_mp_if.slave bus
);
    localparam int NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_PC_IDX  = ADDR_W'(NREG - 1);
    localparam logic [ADDR_W-1:0] c_LAST_GP = ADDR_W'(NREG - 2);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_clr_idx, w_clr_idx_nxt;
    logic [DATA_W-1:0] r_regs [NREG-1];
    logic              r_pc_wr;
    logic [DATA_W-1:0] r_pc_wd;

    logic              w_run;
    logic              w_wr3, w_wr4, w_pc3, w_pc4;
    logic [ADDR_W-1:0] w_ra [3];
    logic [DATA_W-1:0] w_rd [3];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        if (r_state == S_CLEAR) begin
            w_clr_idx_nxt = r_clr_idx + 1'b1;
            if (r_clr_idx == c_LAST_GP) begin
                w_state_nxt = S_RUN;
            end
        end
    end

    assign w_run = (r_state == S_RUN);
    assign w_wr3 = w_run && bus.we3;
    assign w_wr4 = w_run && bus.we4;
    assign w_pc3 = w_wr3 && (bus.wa3 == c_PC_IDX);
    assign w_pc4 = w_wr4 && (bus.wa4 == c_PC_IDX);

    // Port 4 is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == S_CLEAR) begin
                r_regs[r_clr_idx] <= '0;
            end else begin
                if (w_wr3 && !w_pc3) r_regs[bus.wa3] <= bus.wd3;
                if (w_wr4 && !w_pc4) r_regs[bus.wa4] <= bus.wd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_wr <= 1'b0;
            r_pc_wd <= '0;
        end else begin
            r_pc_wr <= w_pc3 || w_pc4;
            if (w_pc4) begin
                r_pc_wd <= bus.wd4;
            end else if (w_pc3) begin
                r_pc_wd <= bus.wd3;
            end
        end
    end

    assign w_ra[0] = bus.ra1;
    assign w_ra[1] = bus.ra2;
    assign w_ra[2] = bus.ra3;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_rd[i] = '0;
            if (w_ra[i] == c_PC_IDX) begin
                w_rd[i] = bus.R15;
            end else if (w_run) begin
                w_rd[i] = r_regs[w_ra[i]];
`ifdef REGFILE_BYPASS_EN
                if (bus.we3 && (bus.wa3 == w_ra[i])) w_rd[i] = bus.wd3;
                if (bus.we4 && (bus.wa4 == w_ra[i])) w_rd[i] = bus.wd4;
`endif
            end
        end
    end

    assign bus.rd1   = w_rd[0];
    assign bus.rd2   = w_rd[1];
    assign bus.rd3   = w_rd[2];
    assign bus.busy  = (r_state == S_CLEAR);
    assign bus.pc_wr = r_pc_wr;
    assign bus.pc_wd = r_pc_wd;

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// Module      : tb_regfile_mp
// Description : Directed plus randomized bench for regfile_mp with an
//               in-bench behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_mp;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int PC = 15;
    localparam int NCLR = 15;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: clear countdown, storage array, pending PC pulse.
    bit          m_known = 1'b0;
    int          m_clear_left = NCLR;
    logic [31:0] m_mem [15];
    bit          m_pc_wr = 1'b0;
    logic [31:0] m_pc_wd = '0;

    function automatic logic [31:0] m_read(input logic [3:0] a);
        logic [31:0] v;
        if (a == 4'(PC)) return bus.R15;
        if (m_clear_left > 0) return 32'h0;
        v = m_mem[a];
`ifdef REGFILE_BYPASS_EN
        if (bus.we3 && bus.wa3 == a) v = bus.wd3;
        if (bus.we4 && bus.wa4 == a) v = bus.wd4;
`endif
        return v;
    endfunction

    initial begin
        bit          pcw;
        logic [31:0] pcd;
        forever begin
            @(negedge clk);
            if (m_known) begin
                check("rd1", bus.rd1, m_read(bus.ra1));
                check("rd2", bus.rd2, m_read(bus.ra2));
                check("rd3", bus.rd3, m_read(bus.ra3));
                check("busy", 32'(bus.busy), 32'(m_clear_left > 0));
                check("pc_wr", 32'(bus.pc_wr), 32'(m_pc_wr));
                if (m_pc_wr) check("pc_wd", bus.pc_wd, m_pc_wd);
            end
            @(posedge clk);
            if (reset) begin
                m_known      = 1'b1;
                m_clear_left = NCLR;
                m_pc_wr      = 1'b0;
                m_pc_wd      = '0;
                foreach (m_mem[k]) m_mem[k] = '0;
            end else if (m_known) begin
                pcw = 1'b0;
                pcd = '0;
                if (m_clear_left > 0) begin
                    m_clear_left--;
                end else begin
                    if (bus.we3) begin
                        if (bus.wa3 == 4'(PC)) begin pcw = 1'b1; pcd = bus.wd3; end
                        else m_mem[bus.wa3] = bus.wd3;
                    end
                    if (bus.we4) begin
                        if (bus.wa4 == 4'(PC)) begin pcw = 1'b1; pcd = bus.wd4; end
                        else m_mem[bus.wa4] = bus.wd4;
                    end
                end
                m_pc_wr = pcw;
                if (pcw) m_pc_wd = pcd;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        bus.we3 = 1'b0;
        bus.we4 = 1'b0;
    endtask

    // Counts edges until busy falls; a blocked write is presented on the first edge.
    task automatic wait_clear(input string name);
        int n;
        n = 0;
        bus.we3 = 1'b1; bus.wa3 = 4'd3; bus.wd3 = 32'h77;
        do begin
            cyc();
            n++;
            idle();
        end while (bus.busy && n < 40);
        check(name, 32'(n), 32'(NCLR));
    endtask

    initial begin
        bus.R15 = 32'h0000_0108;
        bus.ra1 = '0; bus.ra2 = '0; bus.ra3 = '0;
        bus.wa3 = '0; bus.wa4 = '0; bus.wd3 = '0; bus.wd4 = '0;
        idle();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        wait_clear("clear_edges");

        for (int a = 0; a < 15; a++) begin
            bus.ra1 = 4'(a);
            #1 check("cleared_reg", bus.rd1, 32'h0);
        end
        bus.ra1 = 4'd15;
        #1 check("r15_alias", bus.rd1, 32'h0000_0108);

        bus.we3 = 1'b1; bus.wa3 = 4'd5; bus.wd3 = 32'hDEADBEEF; bus.ra2 = 4'd5;
`ifdef REGFILE_BYPASS_EN
        #1 check("bypass_r5", bus.rd2, 32'hDEADBEEF);
`endif
        cyc(); idle();
        #1 check("write_r5", bus.rd2, 32'hDEADBEEF);

        bus.we3 = 1'b1; bus.wa3 = 4'd7; bus.wd3 = 32'h11;
        bus.we4 = 1'b1; bus.wa4 = 4'd7; bus.wd4 = 32'h22;
        cyc();
        bus.wa3 = 4'd2; bus.wd3 = 32'h33;
        bus.wa4 = 4'd9; bus.wd4 = 32'h44;
        cyc(); idle();
        bus.ra1 = 4'd7; bus.ra2 = 4'd2; bus.ra3 = 4'd9;
        #1;
        check("collide_r7", bus.rd1, 32'h22);
        check("dual_r2", bus.rd2, 32'h33);
        check("dual_r9", bus.rd3, 32'h44);

        bus.we4 = 1'b1; bus.wa4 = 4'd15; bus.wd4 = 32'h0000_0400; bus.ra3 = 4'd15;
        #1 check("pc_read_r15", bus.rd3, 32'h0000_0108);
        cyc(); idle();
        #1;
        check("pc_wr_pulse", 32'(bus.pc_wr), 32'd1);
        check("pc_wd_val", bus.pc_wd, 32'h0000_0400);
        cyc();
        #1 check("pc_wr_drop", 32'(bus.pc_wr), 32'd0);

        bus.we3 = 1'b1; bus.wa3 = 4'd4; bus.wd3 = 32'h55; bus.ra1 = 4'd4;
        cyc(); idle();
        #1 check("write_r4", bus.rd1, 32'h55);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        wait_clear("reclear_edges");
        bus.ra1 = 4'd4; bus.ra2 = 4'd3;
        #1;
        check("r4_cleared", bus.rd1, 32'h0);
        check("r3_blocked", bus.rd2, 32'h0);

        repeat (3000) begin
            bus.ra1 = 4'($urandom_range(0, 15));
            bus.ra2 = 4'($urandom_range(0, 15));
            bus.ra3 = 4'($urandom_range(0, 15));
            bus.we3 = 1'($urandom_range(0, 1));
            bus.we4 = 1'($urandom_range(0, 1));
            bus.wa3 = 4'($urandom_range(0, 15));
            bus.wa4 = ($urandom_range(0, 3) == 0) ? bus.wa3 : 4'($urandom_range(0, 15));
            bus.wd3 = $urandom;
            bus.wd4 = $urandom;
            bus.R15 = $urandom;
            reset   = ($urandom_range(0, 199) == 0);
            cyc();
        end
        reset = 1'b0;
        idle();
        repeat (20) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
